// File: rtl/shared_resource_arbiter_n.sv
// rtl/shared_resource_arbiter_n.sv - N-channel round-robin/burst arbiter onto a tagged LAT-stage shared resource
// Optional per-channel grant/stall counters: define SHARED_ARB_PERF_COUNTERS_EN.
module shared_resource_arbiter_n #(
   parameter int N_CH      = 4,
   parameter int DATA_W    = 32,
   parameter int LAT       = 3,
   parameter int MAX_BURST = 1
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic [N_CH-1:0]        i_req,
   input  logic [N_CH*DATA_W-1:0] i_req_data,
   input  logic [N_CH-1:0]        i_flush,
   output logic [N_CH-1:0]        o_grant,
   output logic [N_CH-1:0]        o_stall,
   output logic [N_CH-1:0]        o_resp_valid,
   output logic [DATA_W-1:0]      o_resp_data
`ifdef SHARED_ARB_PERF_COUNTERS_EN
   ,
   output logic [N_CH*16-1:0]     o_grant_cnt,
   output logic [N_CH*16-1:0]     o_stall_cnt
`endif
);

   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int BC_W = $clog2(MAX_BURST + 1);

   logic [CH_W-1:0]   r_ptr;
   logic [CH_W-1:0]   r_owner;
   logic              r_owner_vld;
   logic [BC_W-1:0]   r_burst_cnt;
   logic              r_vld [LAT];
   logic [CH_W-1:0]   r_tag [LAT];
   logic [DATA_W-1:0] r_dat [LAT];

   logic [N_CH-1:0]   w_eff;
   logic              w_hold;
   logic              w_gnt_any;
   logic [CH_W-1:0]   w_gnt_idx;
   logic [DATA_W-1:0] w_gnt_data;
   logic [BC_W-1:0]   w_next_cnt;
   logic              w_burst_done;
   logic [CH_W-1:0]   w_ptr_after_gnt;
   logic [CH_W-1:0]   w_ptr_after_own;

   always_comb begin
      w_eff     = i_req & ~i_flush;
      w_hold    = r_owner_vld && w_eff[r_owner] && (r_burst_cnt < BC_W'(MAX_BURST));
      w_gnt_any = 1'b0;
      w_gnt_idx = '0;
      if (w_hold) begin
         w_gnt_any = 1'b1;
         w_gnt_idx = r_owner;
      end else begin
         // Descending scan so the channel closest to r_ptr is the last writer and wins.
         for (int k = N_CH - 1; k >= 0; k--) begin
            if (w_eff[CH_W'((int'(r_ptr) + k) % N_CH)]) begin
               w_gnt_any = 1'b1;
               w_gnt_idx = CH_W'((int'(r_ptr) + k) % N_CH);
            end
         end
      end
      o_grant = '0;
      if (w_gnt_any) o_grant[w_gnt_idx] = 1'b1;
      o_stall = w_eff & ~o_grant;
   end

   always_comb begin
      w_gnt_data      = i_req_data[w_gnt_idx*DATA_W +: DATA_W];
      w_next_cnt      = (r_owner_vld && (w_gnt_idx == r_owner)) ? r_burst_cnt + 1'b1 : BC_W'(1);
      w_burst_done    = (w_next_cnt >= BC_W'(MAX_BURST));
      w_ptr_after_gnt = (w_gnt_idx == CH_W'(N_CH - 1)) ? '0 : w_gnt_idx + 1'b1;
      w_ptr_after_own = (r_owner == CH_W'(N_CH - 1)) ? '0 : r_owner + 1'b1;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_ptr       <= '0;
         r_owner     <= '0;
         r_owner_vld <= 1'b0;
         r_burst_cnt <= '0;
      end else if (w_gnt_any) begin
         r_burst_cnt <= w_next_cnt;
         if (w_burst_done) begin
            r_ptr       <= w_ptr_after_gnt;
            r_owner_vld <= 1'b0;
         end else begin
            r_owner     <= w_gnt_idx;
            r_owner_vld <= 1'b1;
         end
      end else if (r_owner_vld && !w_eff[r_owner]) begin
         r_ptr       <= w_ptr_after_own;
         r_owner_vld <= 1'b0;
      end
   end

   // Last stage doubles as the response register; a flush kills entries as they advance.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int j = 0; j < LAT; j++) begin
            r_vld[j] <= 1'b0;
            r_tag[j] <= '0;
            r_dat[j] <= '0;
         end
      end else begin
         r_vld[0] <= w_gnt_any;
         r_tag[0] <= w_gnt_idx;
         r_dat[0] <= w_gnt_data + DATA_W'(1);
         for (int j = 1; j < LAT; j++) begin
            r_vld[j] <= r_vld[j-1] && !i_flush[r_tag[j-1]];
            r_tag[j] <= r_tag[j-1];
            r_dat[j] <= r_dat[j-1];
         end
      end
   end

   always_comb begin
      o_resp_valid = '0;
      if (r_vld[LAT-1]) o_resp_valid[r_tag[LAT-1]] = 1'b1;
   end

   assign o_resp_data = r_dat[LAT-1];

`ifdef SHARED_ARB_PERF_COUNTERS_EN
   logic [N_CH*16-1:0] r_grant_cnt;
   logic [N_CH*16-1:0] r_stall_cnt;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_grant_cnt <= '0;
         r_stall_cnt <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (o_grant[i] && (r_grant_cnt[i*16 +: 16] != 16'hFFFF))
               r_grant_cnt[i*16 +: 16] <= r_grant_cnt[i*16 +: 16] + 16'd1;
            if (o_stall[i] && (r_stall_cnt[i*16 +: 16] != 16'hFFFF))
               r_stall_cnt[i*16 +: 16] <= r_stall_cnt[i*16 +: 16] + 16'd1;
         end
      end
   end

   assign o_grant_cnt = r_grant_cnt;
   assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_shared_resource_arbiter_n.sv
// tb/tb_shared_resource_arbiter_n.sv - directed bench with reference model for shared_resource_arbiter_n
module tb_shared_resource_arbiter_n;

   localparam int N   = 4;
   localparam int DW  = 32;
   localparam int LAT = 3;

   logic clk = 1'b0;
   logic rst;
   logic [N-1:0]    req   [2];
   logic [N-1:0]    flush [2];
   logic [N*DW-1:0] data  [2];
   logic [N-1:0]    grant [2];
   logic [N-1:0]    stall [2];
   logic [N-1:0]    rv    [2];
   logic [DW-1:0]   rd    [2];
`ifdef SHARED_ARB_PERF_COUNTERS_EN
   logic [N*16-1:0] gcnt  [2];
   logic [N*16-1:0] scnt  [2];
`endif

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   shared_resource_arbiter_n #(.N_CH(N), .DATA_W(DW), .LAT(LAT), .MAX_BURST(1)) u_rr (
      .i_clk(clk), .i_reset(rst), .i_req(req[0]), .i_req_data(data[0]), .i_flush(flush[0]),
      .o_grant(grant[0]), .o_stall(stall[0]), .o_resp_valid(rv[0]), .o_resp_data(rd[0])
`ifdef SHARED_ARB_PERF_COUNTERS_EN
      , .o_grant_cnt(gcnt[0]), .o_stall_cnt(scnt[0])
`endif
   );

   shared_resource_arbiter_n #(.N_CH(N), .DATA_W(DW), .LAT(LAT), .MAX_BURST(3)) u_bu (
      .i_clk(clk), .i_reset(rst), .i_req(req[1]), .i_req_data(data[1]), .i_flush(flush[1]),
      .o_grant(grant[1]), .o_stall(stall[1]), .o_resp_valid(rv[1]), .o_resp_data(rd[1])
`ifdef SHARED_ARB_PERF_COUNTERS_EN
      , .o_grant_cnt(gcnt[1]), .o_stall_cnt(scnt[1])
`endif
   );

   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s inst=%0d act=%h exp=%h t=%0t", nm, k, act, exp, $time);
      end
   endtask

   // Reference model: arbitration state plus a list of scheduled responses.
   typedef struct { int inst; int due; int tag; logic [DW-1:0] val; } pend_t;
   pend_t pq[$];
   int m_ptr [2];
   int m_own [2];
   int m_cnt [2];
   bit m_ov  [2];
   int gc [2][N];
   int sc [2][N];
   int edge_n = 0;
   int mg, mnc;
   logic [N-1:0] me;

   function automatic int mb(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   function automatic int exp_gnt(input int k);
      logic [N-1:0] e;
      e = req[k] & ~flush[k];
      if (m_ov[k] && e[m_own[k]] && m_cnt[k] < mb(k)) return m_own[k];
      for (int s = 0; s < N; s++)
         if (e[(m_ptr[k] + s) % N]) return (m_ptr[k] + s) % N;
      return -1;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         pq.delete();
         edge_n = 0;
         for (int k = 0; k < 2; k++) begin
            m_ptr[k] = 0; m_own[k] = 0; m_cnt[k] = 0; m_ov[k] = 1'b0;
            for (int i = 0; i < N; i++) begin gc[k][i] = 0; sc[k][i] = 0; end
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            mg = exp_gnt(k);
            me = req[k] & ~flush[k];
            for (int q = pq.size() - 1; q >= 0; q--)
               if (pq[q].inst == k && (pq[q].due < edge_n || flush[k][pq[q].tag])) pq.delete(q);
            for (int i = 0; i < N; i++) begin
               if (mg == i && gc[k][i] < 65535) gc[k][i]++;
               if (me[i] && mg != i && sc[k][i] < 65535) sc[k][i]++;
            end
            if (mg >= 0) begin
               pq.push_back('{inst: k, due: edge_n + LAT - 1, tag: mg, val: data[k][mg*DW +: DW] + 32'd1});
               mnc = (m_ov[k] && m_own[k] == mg) ? m_cnt[k] + 1 : 1;
               if (mnc >= mb(k)) begin
                  m_ptr[k] = (mg + 1) % N; m_ov[k] = 1'b0; m_cnt[k] = mb(k);
               end else begin
                  m_own[k] = mg; m_ov[k] = 1'b1; m_cnt[k] = mnc;
               end
            end else if (m_ov[k] && !me[m_own[k]]) begin
               m_ptr[k] = (m_own[k] + 1) % N; m_ov[k] = 1'b0;
            end
         end
         edge_n++;
      end
   end

   int cg;
   logic [N-1:0] ce, cgv, crv;
   logic [DW-1:0] crd;

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         cg  = exp_gnt(k);
         ce  = req[k] & ~flush[k];
         cgv = (cg >= 0) ? (4'b0001 << cg) : 4'b0000;
         crv = '0;
         crd = '0;
         foreach (pq[q])
            if (pq[q].inst == k && pq[q].due == edge_n - 1) begin
               crv[pq[q].tag] = 1'b1;
               crd = pq[q].val;
            end
         chk("model_grant", k, grant[k], cgv);
         chk("model_stall", k, stall[k], ce & ~cgv);
         chk("model_resp_valid", k, rv[k], crv);
         if (crv != 0) chk("model_resp_data", k, rd[k], crd);
`ifdef SHARED_ARB_PERF_COUNTERS_EN
         for (int i = 0; i < N; i++) begin
            chk("model_grant_cnt", k, gcnt[k][i*16 +: 16], gc[k][i]);
            chk("model_stall_cnt", k, scnt[k][i*16 +: 16], sc[k][i]);
         end
`endif
      end
   end

   logic [3:0]  t1_g  [7]  = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd1, 4'd2, 4'd4};
   logic [3:0]  t1_rv [7]  = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd4, 4'd8};
   logic [31:0] t1_rd [7]  = '{32'h0, 32'h0, 32'h0, 32'h1, 32'h11, 32'h21, 32'h31};
   logic [3:0]  t2_r  [15] = '{4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd0, 4'd3};
   logic [3:0]  t2_g  [15] = '{4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd1, 4'd0, 4'd2};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int k, input logic [N-1:0] r, input logic [N-1:0] f);
      req[k]   = r;
      flush[k] = f;
   endtask

   initial begin
      rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         req[k] = '0; flush[k] = '0; data[k] = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("reset_resp_valid", k, rv[k], 4'b0000);
         chk("reset_resp_data", k, rd[k], 32'h0);
         chk("reset_grant", k, grant[k], 4'b0000);
      end
      rst = 1'b0;
      for (int i = 0; i < N; i++) begin
         data[0][i*DW +: DW] = i * 16;
         data[1][i*DW +: DW] = 32'h100 + i;
      end

      // Pure round robin with every channel requesting.
      drive(0, 4'b1111, 4'b0000);
      for (int c = 0; c < 7; c++) begin
         #1;
         chk("rr_grant", 0, grant[0], t1_g[c]);
         chk("rr_stall", 0, stall[0], 4'b1111 ^ t1_g[c]);
         chk("rr_resp_valid", 0, rv[0], t1_rv[c]);
         if (t1_rv[c] != 0) chk("rr_resp_data", 0, rd[0], t1_rd[c]);
         tick();
      end
      drive(0, 4'b0000, 4'b0000);
      repeat (4) tick();

      // Bursts of three, then an early drop of the owner.
      for (int c = 0; c < 15; c++) begin
         drive(1, t2_r[c], 4'b0000);
         #1;
         chk("burst_grant", 1, grant[1], t2_g[c]);
         tick();
      end
      drive(1, 4'b0000, 4'b0000);
      repeat (4) tick();

      // Operand wrap.
      data[0][2*DW +: DW] = 32'hFFFF_FFFF;
      drive(0, 4'b0100, 4'b0000);
      #1;
      chk("wrap_grant", 0, grant[0], 4'b0100);
      tick();
      drive(0, 4'b0000, 4'b0000);
      tick();
      tick();
      #1;
      chk("wrap_resp_valid", 0, rv[0], 4'b0100);
      chk("wrap_resp_data", 0, rd[0], 32'h0);
      tick();

      // Flush of two in-flight ch2 ops with ch1 traffic around them.
      data[0][1*DW +: DW] = 32'h1000;
      drive(0, 4'b0010, 4'b0000);
      #1; chk("fl_o_grant", 0, grant[0], 4'b0010);
      tick();
      data[0][2*DW +: DW] = 32'hA0;
      drive(0, 4'b0100, 4'b0000);
      #1; chk("fl_p_grant", 0, grant[0], 4'b0100);
      tick();
      data[0][2*DW +: DW] = 32'hB0;
      #1; chk("fl_q_grant", 0, grant[0], 4'b0100);
      tick();
      data[0][1*DW +: DW] = 32'h2000;
      drive(0, 4'b0010, 4'b0100);
      #1;
      chk("fl_r_grant", 0, grant[0], 4'b0010);
      chk("fl_r_resp_valid", 0, rv[0], 4'b0010);
      chk("fl_r_resp_data", 0, rd[0], 32'h1001);
      tick();
      drive(0, 4'b0000, 4'b0000);
      #1; chk("fl_s_resp_valid", 0, rv[0], 4'b0000);
      tick();
      #1; chk("fl_t_resp_valid", 0, rv[0], 4'b0000);
      tick();
      #1;
      chk("fl_u_resp_valid", 0, rv[0], 4'b0010);
      chk("fl_u_resp_data", 0, rd[0], 32'h2001);
      tick();

      // Flush and request on the same channel, another channel requesting.
      drive(0, 4'b1010, 4'b0010);
      #1;
      chk("simul_grant", 0, grant[0], 4'b1000);
      chk("simul_stall", 0, stall[0], 4'b0000);
      tick();
      drive(0, 4'b0000, 4'b0000);
      repeat (3) tick();

      // Asynchronous reset with operations in flight.
      drive(0, 4'b1111, 4'b0000);
      repeat (3) tick();
      #1;
      chk("pre_reset_resp_valid", 0, rv[0], 4'b0001);
      rst = 1'b1;
      drive(0, 4'b0000, 4'b0000);
      #1;
      chk("async_reset_resp_valid", 0, rv[0], 4'b0000);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("post_reset_resp_valid", 0, rv[0], 4'b0000);
         tick();
      end
      drive(0, 4'b1111, 4'b0000);
      #1;
      chk("post_reset_grant", 0, grant[0], 4'b0001);
      tick();
      drive(0, 4'b0000, 4'b0000);
      repeat (5) tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
